// File: rtl/axis_tick_gen.sv
// AXI4-Stream tick source: emits cfg_beats beats tagged with their index, one every cfg_period+1 cycles.
// Optional build macro AXIS_TICK_GEN_OVERRUN_EN keeps the period free-running across stalls and adds sts_overrun.
module axis_tick_gen #(
  parameter int CNTR_WIDTH       = 32,
  parameter int BEAT_WIDTH       = 32,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        run_flag,
  input  logic                        cfg_flag,
  input  logic [CNTR_WIDTH-1:0]       cfg_period,
  input  logic [BEAT_WIDTH-1:0]       cfg_beats,
  output logic                        trg_flag,
  output logic [BEAT_WIDTH-1:0]       sts_data,
`ifdef AXIS_TICK_GEN_OVERRUN_EN
  output logic [BEAT_WIDTH-1:0]       sts_overrun,
`endif
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [CNTR_WIDTH-1:0] period_reg, period_nxt;
  logic [CNTR_WIDTH-1:0] cntr, cntr_nxt;
  logic [BEAT_WIDTH-1:0] remain, remain_nxt;
  logic [BEAT_WIDTH-1:0] idx, idx_nxt;
  logic                  handshake;
  logic [AXIS_TDATA_WIDTH+BEAT_WIDTH-1:0] idx_ext;

`ifdef AXIS_TICK_GEN_OVERRUN_EN
  logic [BEAT_WIDTH-1:0] overrun_cnt, overrun_nxt;
  logic                  pend, pend_nxt;
`endif

  // Countdown start value that makes the next tick land P+1 cycles after the current edge.
  function automatic logic [CNTR_WIDTH-1:0] first_cnt(input logic [CNTR_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - CNTR_WIDTH'(1);
  endfunction

  assign handshake = m_axis_tvalid & m_axis_tready;
  assign sts_data  = remain;
  assign idx_ext   = {{AXIS_TDATA_WIDTH{1'b0}}, idx_nxt};

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_nxt  = state;
    period_nxt = period_reg;
    cntr_nxt   = cntr;
    remain_nxt = remain;
    idx_nxt    = idx;
`ifdef AXIS_TICK_GEN_OVERRUN_EN
    overrun_nxt = overrun_cnt;
    pend_nxt    = pend;
`endif
    case (state)
      S_IDLE, S_WAIT: begin
        if (cfg_flag) begin
          period_nxt = cfg_period;
          remain_nxt = cfg_beats;
          idx_nxt    = '0;
`ifdef AXIS_TICK_GEN_OVERRUN_EN
          overrun_nxt = '0;
          pend_nxt    = 1'b0;
`endif
          if (cfg_beats == '0) begin
            state_nxt = S_IDLE;
          end else if (cfg_period == '0 && run_flag) begin
            state_nxt = S_VALID;
            cntr_nxt  = '0;
          end else begin
            state_nxt = S_WAIT;
            cntr_nxt  = first_cnt(cfg_period);
          end
        end else if (state == S_WAIT && run_flag) begin
          if (cntr == '0) begin
            state_nxt = S_VALID;
            cntr_nxt  = period_reg;
          end else begin
            cntr_nxt = cntr - CNTR_WIDTH'(1);
          end
        end
      end
      S_VALID: begin
`ifdef AXIS_TICK_GEN_OVERRUN_EN
        // The period keeps running while the beat waits; a tick on the accepting edge is not an overrun.
        if (run_flag) begin
          if (cntr == '0) begin
            cntr_nxt = period_reg;
            pend_nxt = 1'b1;
            if (!handshake && overrun_cnt != '1)
              overrun_nxt = overrun_cnt + BEAT_WIDTH'(1);
          end else begin
            cntr_nxt = cntr - CNTR_WIDTH'(1);
          end
        end
`endif
        if (handshake) begin
          remain_nxt = remain - BEAT_WIDTH'(1);
          idx_nxt    = idx + BEAT_WIDTH'(1);
          if (remain == BEAT_WIDTH'(1)) begin
            state_nxt = S_IDLE;
`ifdef AXIS_TICK_GEN_OVERRUN_EN
            pend_nxt  = 1'b0;
          end else if (pend || (run_flag && cntr == '0)) begin
            state_nxt = S_VALID;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = S_WAIT;
          end
`else
          end else if (period_reg == '0 && run_flag) begin
            state_nxt = S_VALID;
          end else begin
            state_nxt = S_WAIT;
            cntr_nxt  = first_cnt(period_reg);
          end
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (areset) begin
      state         <= S_IDLE;
      period_reg    <= '0;
      cntr          <= '0;
      remain        <= '0;
      idx           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      trg_flag      <= 1'b0;
`ifdef AXIS_TICK_GEN_OVERRUN_EN
      overrun_cnt   <= '0;
      pend          <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      period_reg    <= period_nxt;
      cntr          <= cntr_nxt;
      remain        <= remain_nxt;
      idx           <= idx_nxt;
      m_axis_tvalid <= (state_nxt == S_VALID);
      m_axis_tlast  <= (state_nxt == S_VALID) && (remain_nxt == BEAT_WIDTH'(1));
      m_axis_tdata  <= idx_ext[AXIS_TDATA_WIDTH-1:0];
      trg_flag      <= (state_nxt != S_IDLE);
`ifdef AXIS_TICK_GEN_OVERRUN_EN
      overrun_cnt   <= overrun_nxt;
      pend          <= pend_nxt;
`endif
    end
  end

`ifdef AXIS_TICK_GEN_OVERRUN_EN
  assign sts_overrun = overrun_cnt;
`endif

endmodule

// File: tb/tb_axis_tick_gen.sv
// Directed self-checking bench for axis_tick_gen; cycle c means the window after the c-th edge following cfg_flag.
module tb_axis_tick_gen;
  logic        aclk = 1'b0;
  logic        areset;
  logic        run_flag;
  logic        cfg_flag;
  logic [31:0] cfg_period;
  logic [31:0] cfg_beats;
  logic        trg_flag;
  logic [31:0] sts_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
`ifdef AXIS_TICK_GEN_OVERRUN_EN
  logic [31:0] sts_overrun;
`endif

  int total = 0;
  int bad   = 0;

  axis_tick_gen dut (
    .aclk          (aclk),
    .areset        (areset),
    .run_flag      (run_flag),
    .cfg_flag      (cfg_flag),
    .cfg_period    (cfg_period),
    .cfg_beats     (cfg_beats),
    .trg_flag      (trg_flag),
    .sts_data      (sts_data),
`ifdef AXIS_TICK_GEN_OVERRUN_EN
    .sts_overrun   (sts_overrun),
`endif
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  // Advance n edges; inputs are driven and outputs sampled 1 time unit after each edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] p, input logic [31:0] n);
    cfg_period = p;
    cfg_beats  = n;
    cfg_flag   = 1'b1;
    step();
    cfg_flag   = 1'b0;
  endtask

  initial begin
    areset = 1'b1; run_flag = 1'b1; cfg_flag = 1'b0;
    cfg_period = '0; cfg_beats = '0; m_axis_tready = 1'b1;
    step(3);
    areset = 1'b0;
    step();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast",  m_axis_tlast,  0);
    check("rst_trg",    trg_flag,      0);
    check("rst_sts",    sts_data,      0);
    check("rst_tdata",  m_axis_tdata,  0);

    // P=3 N=4: beats at cycles 4,8,12,16.
    load(3, 4);
    for (int c = 1; c <= 17; c++) begin
      check("p3_tvalid", m_axis_tvalid, (c % 4 == 0 && c <= 16));
      check("p3_sts",    sts_data, 4 - (c - 1) / 4);
      check("p3_trg",    trg_flag, c <= 16);
      if (c % 4 == 0 && c <= 16) begin
        check("p3_tdata", m_axis_tdata, c / 4 - 1);
        check("p3_tlast", m_axis_tlast, c == 16);
      end
      if (c < 17) step();
    end

    // P=0 N=5: back-to-back beats.
    load(0, 5);
    for (int c = 1; c <= 5; c++) begin
      check("p0_tvalid", m_axis_tvalid, 1);
      check("p0_tdata",  m_axis_tdata,  c - 1);
      check("p0_tlast",  m_axis_tlast,  c == 5);
      step();
    end
    check("p0_end_tvalid", m_axis_tvalid, 0);
    check("p0_end_trg",    trg_flag,      0);

    // P=2 N=3 with beat 1 stalled for 10 cycles.
    load(2, 3);
    step(2);
    check("bp_b0_tvalid", m_axis_tvalid, 1);
    check("bp_b0_tdata",  m_axis_tdata,  0);
    step();
    m_axis_tready = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) begin
      check("bp_stall_tvalid", m_axis_tvalid, 1);
      check("bp_stall_tdata",  m_axis_tdata,  1);
      check("bp_stall_tlast",  m_axis_tlast,  0);
      check("bp_stall_sts",    sts_data,      2);
      step();
    end
    m_axis_tready = 1'b1;
    check("bp_acc_tdata", m_axis_tdata, 1);
    step();
`ifdef AXIS_TICK_GEN_OVERRUN_EN
    check("bp_b2_tvalid", m_axis_tvalid, 1);
    check("bp_b2_tdata",  m_axis_tdata,  2);
    check("bp_b2_tlast",  m_axis_tlast,  1);
    step();
`else
    check("bp_gap1_tvalid", m_axis_tvalid, 0);
    step();
    check("bp_gap2_tvalid", m_axis_tvalid, 0);
    step();
    check("bp_b2_tvalid", m_axis_tvalid, 1);
    check("bp_b2_tdata",  m_axis_tdata,  2);
    check("bp_b2_tlast",  m_axis_tlast,  1);
    step();
`endif
    check("bp_end_trg", trg_flag, 0);

    // P=5 N=2: run_flag low 4 cycles in WAIT delays beat 0 from cycle 6 to cycle 10.
    load(5, 2);
    step(2);
    run_flag = 1'b0;
    step(4);
    run_flag = 1'b1;
    step(2);
    check("run_c9_tvalid", m_axis_tvalid, 0);
    step();
    check("run_c10_tvalid", m_axis_tvalid, 1);
    check("run_c10_tdata",  m_axis_tdata,  0);
    step();
    m_axis_tready = 1'b0;
    step(5);
    check("run_b1_tvalid", m_axis_tvalid, 1);
    check("run_b1_tlast",  m_axis_tlast,  1);
    run_flag = 1'b0;
    step(3);
    check("run_frozen_tvalid", m_axis_tvalid, 1);
    check("run_frozen_tdata",  m_axis_tdata,  1);
    run_flag = 1'b1;
    m_axis_tready = 1'b1;
    step();
    check("run_end_tvalid", m_axis_tvalid, 0);
    check("run_end_trg",    trg_flag,      0);

    // N=0 load does nothing.
    load(1, 0);
    check("n0_trg",    trg_flag,      0);
    check("n0_tvalid", m_axis_tvalid, 0);
    step(3);
    check("n0_later_tvalid", m_axis_tvalid, 0);

    // cfg_flag during VALID is ignored.
    m_axis_tready = 1'b0;
    load(0, 3);
    cfg_period = 7; cfg_beats = 9; cfg_flag = 1'b1;
    step();
    cfg_flag = 1'b0;
    check("cfgv_tvalid", m_axis_tvalid, 1);
    check("cfgv_tdata",  m_axis_tdata,  0);
    check("cfgv_sts",    sts_data,      3);
    m_axis_tready = 1'b1;
    step();
    check("cfgv_b1_tdata", m_axis_tdata, 1);
    check("cfgv_b1_sts",   sts_data,     2);
    step();
    check("cfgv_b2_tlast", m_axis_tlast, 1);
    step();
    check("cfgv_end_trg", trg_flag, 0);

    // cfg_flag during WAIT restarts with the new P and N.
    load(4, 3);
    step();
    load(2, 2);
    check("cfgw_sts",    sts_data, 2);
    check("cfgw_trg",    trg_flag, 1);
    step();
    check("cfgw_c4_tvalid", m_axis_tvalid, 0);
    step();
    check("cfgw_b0_tvalid", m_axis_tvalid, 1);
    check("cfgw_b0_tdata",  m_axis_tdata,  0);
    check("cfgw_b0_tlast",  m_axis_tlast,  0);
    step(3);
    check("cfgw_b1_tdata", m_axis_tdata, 1);
    check("cfgw_b1_tlast", m_axis_tlast, 1);
    step();
    check("cfgw_end_trg", trg_flag, 0);

    // Reset while a beat is pending.
    m_axis_tready = 1'b0;
    load(0, 3);
    check("rstv_pre_tvalid", m_axis_tvalid, 1);
    areset = 1'b1;
    step();
    check("rstv_tvalid", m_axis_tvalid, 0);
    check("rstv_trg",    trg_flag,      0);
    check("rstv_sts",    sts_data,      0);
    check("rstv_tdata",  m_axis_tdata,  0);
    areset = 1'b0;
    step();

`ifdef AXIS_TICK_GEN_OVERRUN_EN
    // P=1 with beat 0 stalled 7 cycles: expiries at the ends of cycles 3, 5, 7.
    load(1, 2);
    step();
    check("ovr_b0_tvalid", m_axis_tvalid, 1);
    step(7);
    check("ovr_count",     sts_overrun,   3);
    check("ovr_b0_tdata",  m_axis_tdata,  0);
    m_axis_tready = 1'b1;
    step();
    check("ovr_b1_tvalid", m_axis_tvalid, 1);
    check("ovr_b1_tdata",  m_axis_tdata,  1);
    check("ovr_hold",      sts_overrun,   3);
    step();
    check("ovr_end_trg",   trg_flag,      0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_tick_gen.md
Name: axis_tick_gen

Overview:
AXI4-Stream master that paces and emits a programmed number of beats at a programmed interval. It is the source-side counterpart to the stream-consuming down-counter timer. It sits between PS configuration/status registers and any stream sink that needs timed tokens, such as a DAC sequencer, gate or DMA trigger. Each beat carries its beat index, and the final beat is flagged with tlast.

Parameters:
CNTR_WIDTH, 32, width of period counter and cfg_period
BEAT_WIDTH, 32, width of beat counter, cfg_beats and sts_data
AXIS_TDATA_WIDTH, 32, width of m_axis_tdata; beat index zero-extended or truncated to fit

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  reset, synchronous, active-high
run_flag  input  1  high: period counter advances; low: pacing frozen
cfg_flag  input  1  one-cycle load strobe; starts or restarts a sequence
cfg_period  input  CNTR_WIDTH  P; beats issued every P+1 cycles with tready high
cfg_beats  input  BEAT_WIDTH  N; number of beats in the sequence
trg_flag  output  1  high while a sequence is active (state != IDLE)
sts_data  output  BEAT_WIDTH  beats remaining, not yet accepted
m_axis_tdata  output  AXIS_TDATA_WIDTH  beat index, 0..N-1
m_axis_tvalid  output  1  beat valid
m_axis_tready  input  1  sink ready
m_axis_tlast  output  1  high on beat index N-1

Behaviour:
- Reset (areset=1 at an edge): state IDLE; tvalid, tlast, trg_flag = 0; tdata, sts_data, period register, counters = 0. A reset mid-sequence aborts immediately, including a pending beat.
- All outputs are registered. There is no combinational path from m_axis_tready to any output.
- Registers: period_reg (latched P), cntr (period countdown), remain (beats left), idx (beat index).
- Load, on cfg_flag in state IDLE or WAIT:
  - latch period_reg=P, remain=N, idx=0.
  - If N=0: go to IDLE.
  - Else if P=0 and run_flag=1: go to VALID.
  - Else if P=0: go to WAIT with cntr=0.
  - Else: go to WAIT with cntr=P-1.
- cfg_flag in state VALID is ignored. tvalid is never withdrawn without a handshake.
- IDLE: tvalid=0; wait for cfg_flag.
- WAIT:
  - run_flag=0: cntr holds.
  - run_flag=1 and cntr!=0: cntr decrements.
  - run_flag=1 and cntr=0: go to VALID.
- VALID: tvalid=1, tdata=idx, tlast=(remain==1). Outputs stay stable until tvalid&tready.
- Handshake (tvalid&tready): remain-1, idx+1.
  - If remain was 1: go to IDLE and clear tvalid/tlast.
  - Else apply the same P=0/run_flag rule as Load: go to VALID, or go to WAIT with cntr = (P=0 ? 0 : P-1).
- Timing with run_flag=1 and tready=1:
  - first tvalid appears P+1 cycles after the cfg_flag edge;
  - subsequent tvalid rising points are P+1 cycles apart;
  - P=0 gives back-to-back beats.
- Backpressure: the period count does not start until the handshake, so a stall delays all later beats (no drift compensation in the base build).
- run_flag low in VALID does not drop tvalid. It only freezes WAIT.
- cfg_flag in WAIT restarts cleanly: idx resets to 0 and the new N and P take effect.
- Arithmetic: unsigned; remain never underflows, since the VALID→IDLE transition happens at remain=1. idx wraps modulo 2^BEAT_WIDTH.
- trg_flag = (state != IDLE), registered. sts_data = remain.

Optional Feature:
Macro AXIS_TICK_GEN_OVERRUN_EN.
- Defined:
  - The period counter free-runs in VALID as well, reloading P on each expiry.
  - Each expiry while the current beat is still unaccepted increments a saturating BEAT_WIDTH counter on an extra output port sts_overrun. The counter clears on reset and on cfg_flag.
  - After a handshake, if a tick has already expired, the next beat is issued on the following cycle. Beats are not queued: at most one pending tick is retained.
  - This keeps the long-run beat rate locked to aclk/(P+1) despite stalls.
- Undefined: the sts_overrun port is absent and behaviour is exactly as in Behaviour.

Test Plan:
- P=3, N=4, run=1, tready=1, cfg at cycle 0 -> tvalid rises at cycles 4, 8, 12, 16; tdata 0,1,2,3; tlast only on the beat with tdata=3; trg_flag falls the cycle after the last handshake; sts_data counts 4→0.
- P=0, N=5, tready=1 -> five consecutive tvalid cycles, tdata 0..4, tlast on 4.
- P=2, N=3, tready held low 10 cycles on beat 1 -> tdata=1 and tlast=0 stay stable throughout, tvalid stays high, no beat is lost; beat 2 appears 3 cycles after the beat-1 handshake.
- P=5, N=2, run_flag dropped 4 cycles mid-WAIT -> first beat is delayed by exactly 4 cycles; run_flag dropped while in VALID -> tvalid stays high.
- cfg_flag with N=0 -> trg_flag stays 0 and there is no tvalid. cfg_flag during VALID -> ignored. cfg_flag during WAIT with N=2 -> restart at idx 0.
- areset asserted while tvalid=1 -> next cycle tvalid=0, trg_flag=0, sts_data=0. With AXIS_TICK_GEN_OVERRUN_EN, P=1 and tready low for 7 cycles -> sts_overrun=3.
